// File: rtl/data_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module : data_mem_responder_pkg
// Brief  : Shared funct3 codes, FSM encoding, WAIT counter width and access
//          legality helpers for the data memory responder.
// Rev    : 1.0  initial release
// ============================================================================
package data_mem_responder_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int c_wait_cnt_w = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Unsigned sizes exist only for loads.
    function automatic logic f3_legal(input logic write, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: f3_legal = 1'b1;
            F3_BU, F3_HU:     f3_legal = ~write;
            default:          f3_legal = 1'b0;
        endcase
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lane);
        case (f3)
            F3_H, F3_HU: f3_misaligned = lane[0];
            F3_W:        f3_misaligned = (lane != 2'b00);
            default:     f3_misaligned = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_load_extend.sv
`default_nettype none
// ============================================================================
// Module : load_extend
// Brief  : Selects the addressed byte/half of a RAM word and sign- or
//          zero-extends it according to the RV32I load funct3.
// Rev    : 1.0  initial release
// ============================================================================
module load_extend
    import data_mem_responder_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = word[{lane, 3'b000} +: 8];
        w_half = lane[1] ? word[31:16] : word[15:0];
        rdata  = '0;
        case (funct3)
            F3_B:    rdata = {{24{w_byte[7]}}, w_byte};
            F3_BU:   rdata = {24'h000000, w_byte};
            F3_H:    rdata = {{16{w_half[15]}}, w_half};
            F3_HU:   rdata = {16'h0000, w_half};
            F3_W:    rdata = word;
            default: rdata = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module : data_mem_responder
// Brief  : Single-outstanding load/store responder owning a word-organised
//          data RAM, with fixed response latency and access error flagging.
// Rev    : 1.0  initial release
// ============================================================================
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);

    localparam int                      c_idx_w       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [29:0]             c_depth_words = 30'(DEPTH_WORDS);
    localparam logic [c_wait_cnt_w-1:0] c_wait_load   = c_wait_cnt_w'(WAIT_CYCLES);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [c_wait_cnt_w-1:0] r_cnt;
    logic                    r_write;
    logic [31:0]             r_addr;
    logic [31:0]             r_wdata;
    logic [2:0]              r_funct3;
    logic [31:0]             r_rdata;
    logic                    r_error;
    logic [31:0]             r_mem [DEPTH_WORDS];

    logic                    w_accept;
    logic                    w_enter_resp;
    logic                    w_cur_write;
    logic [31:0]             w_cur_addr;
    logic [31:0]             w_cur_wdata;
    logic [2:0]              w_cur_funct3;
    logic [c_idx_w-1:0]      w_idx;
    logic [1:0]              w_lane;
    logic                    w_error;
    logic [31:0]             w_old_word;
    logic [31:0]             w_lane_mask;
    logic [31:0]             w_lane_data;
    logic [31:0]             w_merged;
    logic [31:0]             w_load_data;

    // With zero wait the RESP edge is the accept edge, so the live request is used.
    always_comb begin
        if (r_state == ST_IDLE) begin
            w_cur_write  = req_write;
            w_cur_addr   = req_addr;
            w_cur_wdata  = req_wdata;
            w_cur_funct3 = req_funct3;
        end else begin
            w_cur_write  = r_write;
            w_cur_addr   = r_addr;
            w_cur_wdata  = r_wdata;
            w_cur_funct3 = r_funct3;
        end
    end

    assign w_idx      = w_cur_addr[c_idx_w+1:2];
    assign w_lane     = w_cur_addr[1:0];
    assign w_error    = ~f3_legal(w_cur_write, w_cur_funct3)
                      | f3_misaligned(w_cur_funct3, w_lane)
                      | (w_cur_addr[31:2] >= c_depth_words);
    assign w_old_word = r_mem[w_idx];

    always_comb begin
        w_lane_mask = '0;
        w_lane_data = w_cur_wdata;
        case (w_cur_funct3)
            F3_B: begin
                w_lane_mask = 32'h0000_00FF << {w_lane, 3'b000};
                w_lane_data = {4{w_cur_wdata[7:0]}};
            end
            F3_H: begin
                w_lane_mask = w_lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                w_lane_data = {2{w_cur_wdata[15:0]}};
            end
            F3_W: begin
                w_lane_mask = 32'hFFFF_FFFF;
            end
            default: w_lane_mask = '0;
        endcase
        w_merged = (w_old_word & ~w_lane_mask) | (w_lane_data & w_lane_mask);
    end

    load_extend u_load_extend (
        .word   (w_old_word),
        .lane   (w_lane),
        .funct3 (w_cur_funct3),
        .rdata  (w_load_data)
    );

    assign w_accept = req_valid && (r_state == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_enter_resp = 1'b0;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        w_state_nxt  = ST_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt <= c_wait_cnt_w'(1)) begin
                    w_state_nxt  = ST_RESP;
                    w_enter_resp = 1'b1;
                end
            end
            ST_RESP: begin
                resp_valid  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_write  <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_funct3 <= '0;
        end else if (w_accept) begin
            r_cnt    <= c_wait_load;
            r_write  <= req_write;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_funct3 <= req_funct3;
        end else if (r_state == ST_WAIT) begin
            r_cnt <= r_cnt - c_wait_cnt_w'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
            r_error <= 1'b0;
        end else if (w_enter_resp) begin
            r_rdata <= (w_error || w_cur_write) ? 32'h0 : w_load_data;
            r_error <= w_error;
        end
    end

    // RAM is not reset; the rst_n term keeps an aborted store from landing.
    always_ff @(posedge clk) begin
        if (rst_n && w_enter_resp && w_cur_write && !w_error) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    assign resp_rdata = r_rdata;
    assign resp_error = r_error;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_data_mem_responder
// Brief  : Directed self-checking bench for data_mem_responder (WAIT_CYCLES=1
//          and WAIT_CYCLES=0 instances sharing one request bus).
// Rev    : 1.0  initial release
// ============================================================================
module tb_data_mem_responder;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;

    logic        ready1, valid1, err1;
    logic [31:0] rdata1;
    logic        ready0, valid0, err0;
    logic [31:0] rdata0;

    int n_pass;
    int n_total;

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (ready1),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .resp_valid (valid1),
        .resp_rdata (rdata1),
        .resp_error (err1)
    );

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut_w0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (ready0),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .resp_valid (valid0),
        .resp_rdata (rdata0),
        .resp_error (err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one request and returns the response seen on the selected instance.
    task automatic do_req(input logic sel0, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] f3,
                          output logic [31:0] rd, output logic er, output int lat,
                          output logic one_cycle);
        rd = 'x;
        er = 1'bx;
        lat = 0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = wr;
        req_addr   = addr;
        req_wdata  = wdata;
        req_funct3 = f3;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if ((sel0 ? valid0 : valid1) === 1'b1) begin
                lat = i;
                rd  = sel0 ? rdata0 : rdata1;
                er  = sel0 ? err0 : err1;
                break;
            end
        end
        @(negedge clk);
        one_cycle = ((sel0 ? valid0 : valid1) === 1'b0);
    endtask

    task automatic test_reset();
        n_total++; if (ready1 !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready1); else n_pass++;
        n_total++; if (valid1 !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid1); else n_pass++;
        n_total++; if (rdata1 !== 32'h0) $display("FAIL reset_rdata: got %h want 0", rdata1); else n_pass++;
        n_total++; if (err1 !== 1'b0) $display("FAIL reset_error: got %b want 0", err1); else n_pass++;
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er; int lat; logic one;
        do_req(1'b0 ^ 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, rd, er, lat, one);
        n_total++; if (lat != 2) $display("FAIL sw_latency: got %0d want 2", lat); else n_pass++;
        n_total++; if (er !== 1'b0 || rd !== 32'h0) $display("FAIL sw_resp: got err=%b rdata=%h want err=0 rdata=0", er, rd); else n_pass++;
        n_total++; if (one !== 1'b1) $display("FAIL sw_pulse_width: got %b want 1", one); else n_pass++;
        do_req(1'b0, 1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat, one);
        n_total++; if (lat != 2) $display("FAIL lw_latency: got %0d want 2", lat); else n_pass++;
        n_total++; if (rd !== 32'hDEADBEEF || er !== 1'b0) $display("FAIL lw_10: got %h err=%b want deadbeef err=0", rd, er); else n_pass++;
    endtask

    task automatic test_byte();
        logic [31:0] rd; logic er; int lat; logic one;
        do_req(1'b0, 1'b1, 32'h13, 32'h00000080, 3'b000, rd, er, lat, one);
        n_total++; if (er !== 1'b0) $display("FAIL sb_13_err: got %b want 0", er); else n_pass++;
        do_req(1'b0, 1'b0, 32'h13, 32'h0, 3'b000, rd, er, lat, one);
        n_total++; if (rd !== 32'hFFFFFF80) $display("FAIL lb_13: got %h want ffffff80", rd); else n_pass++;
        do_req(1'b0, 1'b0, 32'h13, 32'h0, 3'b100, rd, er, lat, one);
        n_total++; if (rd !== 32'h00000080) $display("FAIL lbu_13: got %h want 00000080", rd); else n_pass++;
        do_req(1'b0, 1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat, one);
        n_total++; if (rd !== 32'h80ADBEEF) $display("FAIL lw_after_sb: got %h want 80adbeef", rd); else n_pass++;
        do_req(1'b0, 1'b0, 32'h11, 32'h0, 3'b000, rd, er, lat, one);
        n_total++; if (rd !== 32'hFFFFFFBE) $display("FAIL lb_11: got %h want ffffffbe", rd); else n_pass++;
    endtask

    task automatic test_half();
        logic [31:0] rd; logic er; int lat; logic one;
        do_req(1'b0, 1'b1, 32'h22, 32'h00001234, 3'b001, rd, er, lat, one);
        do_req(1'b0, 1'b0, 32'h22, 32'h0, 3'b001, rd, er, lat, one);
        n_total++; if (rd !== 32'h00001234 || er !== 1'b0) $display("FAIL lh_22: got %h err=%b want 00001234 err=0", rd, er); else n_pass++;
        do_req(1'b0, 1'b0, 32'h20, 32'h0, 3'b010, rd, er, lat, one);
        n_total++; if (rd[31:16] !== 16'h1234) $display("FAIL lw_20_upper: got %h want 1234", rd[31:16]); else n_pass++;
        do_req(1'b0, 1'b0, 32'h21, 32'h0, 3'b001, rd, er, lat, one);
        n_total++; if (er !== 1'b1 || rd !== 32'h0) $display("FAIL lh_21_misaligned: got err=%b rdata=%h want err=1 rdata=0", er, rd); else n_pass++;
        do_req(1'b0, 1'b1, 32'h24, 32'h0000F00D, 3'b001, rd, er, lat, one);
        do_req(1'b0, 1'b0, 32'h24, 32'h0, 3'b001, rd, er, lat, one);
        n_total++; if (rd !== 32'hFFFFF00D) $display("FAIL lh_24: got %h want fffff00d", rd); else n_pass++;
        do_req(1'b0, 1'b0, 32'h24, 32'h0, 3'b101, rd, er, lat, one);
        n_total++; if (rd !== 32'h0000F00D) $display("FAIL lhu_24: got %h want 0000f00d", rd); else n_pass++;
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat; logic one;
        do_req(1'b0, 1'b1, 32'hFFC, 32'hA0A0A0A0, 3'b010, rd, er, lat, one);
        do_req(1'b0, 1'b1, 32'h000, 32'h5A5A5A5A, 3'b010, rd, er, lat, one);
        do_req(1'b0, 1'b1, 32'h100, 32'h11111111, 3'b010, rd, er, lat, one);
        do_req(1'b0, 1'b1, 32'h104, 32'h22222222, 3'b010, rd, er, lat, one);
        do_req(1'b0, 1'b1, 32'h1002, 32'hFFFFFFFF, 3'b010, rd, er, lat, one);
        n_total++; if (er !== 1'b1) $display("FAIL sw_1002_err: got %b want 1", er); else n_pass++;
        do_req(1'b0, 1'b1, 32'h102, 32'hFFFFFFFF, 3'b010, rd, er, lat, one);
        n_total++; if (er !== 1'b1 || rd !== 32'h0) $display("FAIL sw_102_err: got err=%b rdata=%h want err=1 rdata=0", er, rd); else n_pass++;
        do_req(1'b0, 1'b1, 32'h1000, 32'hFFFFFFFF, 3'b010, rd, er, lat, one);
        n_total++; if (er !== 1'b1) $display("FAIL sw_oor_err: got %b want 1", er); else n_pass++;
        do_req(1'b0, 1'b0, 32'h100, 32'h0, 3'b010, rd, er, lat, one);
        n_total++; if (rd !== 32'h11111111) $display("FAIL lw_100_kept: got %h want 11111111", rd); else n_pass++;
        do_req(1'b0, 1'b0, 32'h104, 32'h0, 3'b010, rd, er, lat, one);
        n_total++; if (rd !== 32'h22222222) $display("FAIL lw_104_kept: got %h want 22222222", rd); else n_pass++;
        do_req(1'b0, 1'b0, 32'hFFC, 32'h0, 3'b010, rd, er, lat, one);
        n_total++; if (rd !== 32'hA0A0A0A0) $display("FAIL lw_ffc_kept: got %h want a0a0a0a0", rd); else n_pass++;
        do_req(1'b0, 1'b0, 32'h000, 32'h0, 3'b010, rd, er, lat, one);
        n_total++; if (rd !== 32'h5A5A5A5A) $display("FAIL lw_000_kept: got %h want 5a5a5a5a", rd); else n_pass++;
        do_req(1'b0, 1'b0, 32'h1000, 32'h0, 3'b010, rd, er, lat, one);
        n_total++; if (er !== 1'b1 || rd !== 32'h0) $display("FAIL lw_oor: got err=%b rdata=%h want err=1 rdata=0", er, rd); else n_pass++;
        do_req(1'b0, 1'b0, 32'h100, 32'h0, 3'b011, rd, er, lat, one);
        n_total++; if (er !== 1'b1 || rd !== 32'h0) $display("FAIL ld_f3_011: got err=%b rdata=%h want err=1 rdata=0", er, rd); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int lat; logic one;
        do_req(1'b0, 1'b1, 32'h30, 32'hAABBCCDD, 3'b010, rd, er, lat, one);
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_addr   = 32'h30;
        req_wdata  = 32'h00000011;
        req_funct3 = 3'b100;
        n_total++; if (ready1 !== 1'b1) $display("FAIL b2b_ready_idle: got %b want 1", ready1); else n_pass++;
        @(negedge clk);
        n_total++; if (ready1 !== 1'b0 || valid1 !== 1'b0) $display("FAIL b2b_wait: got ready=%b valid=%b want 0 0", ready1, valid1); else n_pass++;
        @(negedge clk);
        n_total++; if (ready1 !== 1'b0 || valid1 !== 1'b1 || err1 !== 1'b1) $display("FAIL b2b_resp: got ready=%b valid=%b err=%b want 0 1 1", ready1, valid1, err1); else n_pass++;
        @(negedge clk);
        n_total++; if (ready1 !== 1'b1 || valid1 !== 1'b0) $display("FAIL b2b_back_idle: got ready=%b valid=%b want 1 0", ready1, valid1); else n_pass++;
        req_valid = 1'b0;
        do_req(1'b0, 1'b0, 32'h30, 32'h0, 3'b010, rd, er, lat, one);
        n_total++; if (rd !== 32'hAABBCCDD) $display("FAIL sbu_no_write: got %h want aabbccdd", rd); else n_pass++;
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic er; int lat; logic one; logic seen;
        do_req(1'b0, 1'b1, 32'h40, 32'h0BADF00D, 3'b010, rd, er, lat, one);
        do_req(1'b0, 1'b0, 32'h40, 32'h0, 3'b010, rd, er, lat, one);
        n_total++; if (rd !== 32'h0BADF00D) $display("FAIL lw_40_pre: got %h want 0badf00d", rd); else n_pass++;
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_addr   = 32'h40;
        req_wdata  = 32'h00000055;
        req_funct3 = 3'b010;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (ready1 !== 1'b1 || valid1 !== 1'b0 || rdata1 !== 32'h0 || err1 !== 1'b0)
            $display("FAIL abort_reset_vals: got ready=%b valid=%b rdata=%h err=%b want 1 0 0 0", ready1, valid1, rdata1, err1);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (valid1 !== 1'b0) seen = 1'b1;
        end
        n_total++; if (seen !== 1'b0) $display("FAIL abort_no_resp: got %b want 0", seen); else n_pass++;
        do_req(1'b0, 1'b0, 32'h40, 32'h0, 3'b010, rd, er, lat, one);
        n_total++; if (rd !== 32'h0BADF00D) $display("FAIL lw_40_post: got %h want 0badf00d", rd); else n_pass++;
    endtask

    task automatic test_zero_wait();
        logic [31:0] rd; logic er; int lat; logic one;
        do_req(1'b1, 1'b1, 32'h80, 32'hCAFEF00D, 3'b010, rd, er, lat, one);
        n_total++; if (lat != 1) $display("FAIL w0_sw_latency: got %0d want 1", lat); else n_pass++;
        n_total++; if (one !== 1'b1) $display("FAIL w0_pulse_width: got %b want 1", one); else n_pass++;
        do_req(1'b1, 1'b0, 32'h80, 32'h0, 3'b010, rd, er, lat, one);
        n_total++; if (lat != 1) $display("FAIL w0_lw_latency: got %0d want 1", lat); else n_pass++;
        n_total++; if (rd !== 32'hCAFEF00D || er !== 1'b0) $display("FAIL w0_lw_80: got %h err=%b want cafef00d err=0", rd, er); else n_pass++;
        do_req(1'b1, 1'b0, 32'h82, 32'h0, 3'b001, rd, er, lat, one);
        n_total++; if (rd !== 32'hFFFFCAFE) $display("FAIL w0_lh_82: got %h want ffffcafe", rd); else n_pass++;
    endtask

    initial begin
        n_pass     = 0;
        n_total    = 0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_funct3 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_back_to_back();
        test_reset_abort();
        test_zero_wait();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
